// File: rtl/wdt_controller.sv
// Two-stage watchdog: the first timeout raises irq and reloads the counter.
// A second timeout, or a kick with the wrong key, pulses soc_fault toward the reset controller.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module wdt_controller #(
  parameter int unsigned PRESCALE    = 1024,
  parameter logic [7:0]  FAULT_CAUSE = 8'h10,
  parameter logic [15:0] KICK_KEY    = 16'h5A5A
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault,
  output logic                      irq,
  output logic                      soc_fault,
  output logic [7:0]                soc_fault_cause,
  output logic [`XLEN-1:0]          soc_fault_addr
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  // acc encoding: 0 = byte, 1 = halfword, 2 = word
  localparam logic [`BUS_ACC_WIDTH-1:0] ACC_2B = 1;
  localparam logic [`BUS_ACC_WIDTH-1:0] ACC_4B = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WARN,
    FIRE
  } state_t;

  state_t state;

  logic          en;
  logic          lock;
  logic [31:0]   load;
  logic [31:0]   cnt;
  logic [PW-1:0] presc;

  logic sel_ctrl;
  logic sel_kick;
  logic sel_load;
  logic sel_cnt;
  logic ok;
  logic valid;
  logic wr;
  logic rd;
  logic ctrl_w;
  logic kick_w;
  logic load_w;
  logic active;
  logic tick;
  logic good_key;

  logic [`BUS_WIDTH-1:0] rd_mux;

  assign sel_ctrl = (addr == 4'd0);
  assign sel_kick = (addr == 4'd2);
  assign sel_load = (addr == 4'd4);
  assign sel_cnt  = (addr == 4'd8);

  always_comb begin
    ok = 1'b0;
    unique case (1'b1)
      sel_ctrl: ok = (acc == ACC_2B) && !(w_rb && lock);
      sel_kick: ok = (acc == ACC_2B) && w_rb;
      sel_load: ok = (acc == ACC_4B) && !(w_rb && lock);
      sel_cnt:  ok = (acc == ACC_4B) && !w_rb;
      default:  ok = 1'b0;
    endcase
  end

  assign valid  = req && ok;
  assign fault  = req && !ok;
  assign wr     = valid && w_rb;
  assign rd     = valid && !w_rb;
  assign ctrl_w = wr && sel_ctrl;
  assign kick_w = wr && sel_kick;
  assign load_w = wr && sel_load;

  assign active   = (state == RUN) || (state == WARN);
  assign tick     = active && (presc == PS_MAX);
  assign good_key = (wdata[15:0] == KICK_KEY);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: rd_mux = {30'd0, lock, en};
      sel_load: rd_mux = load;
      sel_cnt:  rd_mux = cnt;
      default:  rd_mux = '0;
    endcase
  end

  assign soc_fault_cause = soc_fault ? FAULT_CAUSE : 8'h00;
  assign soc_fault_addr  = soc_fault ? load : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      en        <= 1'b0;
      lock      <= 1'b0;
      load      <= 32'h0000_FFFF;
      cnt       <= 32'h0000_FFFF;
      presc     <= '0;
      rdata     <= '0;
      resp      <= 1'b0;
      irq       <= 1'b0;
      soc_fault <= 1'b0;
    end else begin
      resp      <= valid;
      soc_fault <= 1'b0;
      if (rd) begin
        rdata <= rd_mux;
      end
      if (load_w) begin
        load <= wdata;
      end
      if (ctrl_w) begin
        lock <= lock | wdata[1];
      end
      unique case (state)
        IDLE: begin
          if (ctrl_w && wdata[0]) begin
            en    <= 1'b1;
            cnt   <= load;
            presc <= '0;
            state <= RUN;
          end
        end
        RUN, WARN: begin
          // bus events beat a tick landing on the same edge
          if (kick_w && good_key) begin
            cnt   <= load;
            presc <= '0;
            irq   <= 1'b0;
            state <= RUN;
          end else if (kick_w) begin
            soc_fault <= 1'b1;
            state     <= FIRE;
          end else if (ctrl_w && !wdata[0]) begin
            en    <= 1'b0;
            irq   <= 1'b0;
            state <= IDLE;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (cnt != '0) begin
                cnt <= cnt - 32'd1;
              end else if (state == RUN) begin
                cnt   <= load;
                irq   <= 1'b1;
                state <= WARN;
              end else begin
                soc_fault <= 1'b1;
                state     <= FIRE;
              end
            end
          end
        end
        FIRE: begin
          en    <= 1'b0;
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_controller.sv
// Randomised bench for wdt_controller with a deadline-based reference model.
// A driver pushes expected responses; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_wdt_controller;

  localparam int P = 4;
  localparam logic [15:0] KEY = 16'h5A5A;
  localparam logic [7:0] CAUSE = 8'h10;
  localparam logic [1:0] A2 = 2'd1;
  localparam logic [1:0] A4 = 2'd2;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_WARN = 2;
  localparam int M_FIRE = 3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] addr;
  logic w_rb;
  logic [1:0] acc;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic req;
  logic resp;
  logic fault;
  logic irq;
  logic soc_fault;
  logic [7:0] soc_fault_cause;
  logic [31:0] soc_fault_addr;

  always #5 clk = ~clk;

  wdt_controller #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc),
    .rdata(rdata), .wdata(wdata), .req(req), .resp(resp),
    .fault(fault), .irq(irq), .soc_fault(soc_fault),
    .soc_fault_cause(soc_fault_cause), .soc_fault_addr(soc_fault_addr)
  );

  typedef struct {
    bit resp;
    bit irq;
    bit sf;
    logic [31:0] faddr;
  } stat_t;

  typedef struct {
    bit rd;
    logic [31:0] data;
  } rsp_t;

  stat_t stat_q[$];
  rsp_t rsp_q[$];

  int compared = 0;
  int mismatched = 0;
  int irq_hi = 0;
  int sf_hi = 0;
  longint edge_n = 0;

  // reference model: each phase is a start edge plus a starting count;
  // the count and the expiry edge follow from plain arithmetic
  int m_mode;
  longint m_start;
  longint m_cnt0;
  logic [31:0] m_frozen;
  logic [31:0] m_load;
  bit m_irq;
  bit m_lock;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_start = 0;
    m_cnt0 = 0;
    m_frozen = 32'h0000_FFFF;
    m_load = 32'h0000_FFFF;
    m_irq = 1'b0;
    m_lock = 1'b0;
  endfunction

  function automatic logic [31:0] cnt_at(longint e);
    if (m_mode == M_RUN || m_mode == M_WARN)
      return 32'(m_cnt0 - (e - m_start) / P);
    return m_frozen;
  endfunction

  function automatic bit legal(logic [3:0] a, bit w, logic [1:0] ac);
    case (a)
      4'd0: return (ac == A2) && !(w && m_lock);
      4'd2: return (ac == A2) && w;
      4'd4: return (ac == A4) && !(w && m_lock);
      4'd8: return (ac == A4) && !w;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(longint e, bit v, bit w, logic [3:0] a,
                            logic [31:0] d, output logic [31:0] rdx);
    logic [31:0] pre;
    bit busy;
    bit done;
    pre = cnt_at(e - 1);
    busy = (m_mode == M_RUN) || (m_mode == M_WARN);
    done = 1'b0;
    rdx = '0;
    if (v && !w) begin
      case (a)
        4'd0: rdx = {30'd0, m_lock, m_mode != M_IDLE};
        4'd4: rdx = m_load;
        4'd8: rdx = pre;
        default: rdx = '0;
      endcase
    end
    if (m_mode == M_FIRE) begin
      m_mode = M_IDLE;
      m_irq = 1'b0;
      done = 1'b1;
    end else if (v && w && a == 4'd2 && busy) begin
      done = 1'b1;
      if (d[15:0] == KEY) begin
        m_mode = M_RUN;
        m_start = e;
        m_cnt0 = m_load;
        m_irq = 1'b0;
      end else begin
        m_mode = M_FIRE;
        m_frozen = pre;
      end
    end else if (v && w && a == 4'd0) begin
      if (m_mode == M_IDLE && d[0]) begin
        m_mode = M_RUN;
        m_start = e;
        m_cnt0 = m_load;
        done = 1'b1;
      end else if (busy && !d[0]) begin
        m_mode = M_IDLE;
        m_frozen = pre;
        m_irq = 1'b0;
        done = 1'b1;
      end
    end
    if (!done && busy && e == m_start + (m_cnt0 + 1) * P) begin
      if (m_mode == M_RUN) begin
        m_mode = M_WARN;
        m_start = e;
        m_cnt0 = m_load;
        m_irq = 1'b1;
      end else begin
        m_mode = M_FIRE;
        m_frozen = '0;
      end
    end
    if (v && w && a == 4'd0) m_lock = m_lock | d[1];
    if (v && w && a == 4'd4) m_load = d;
  endtask

  task automatic step(bit r, bit q, bit w, logic [3:0] a,
                      logic [1:0] ac, logic [31:0] d);
    stat_t st;
    bit v;
    logic [31:0] rdx;
    longint e;
    @(negedge clk);
    rst = r;
    req = q;
    w_rb = w;
    addr = a;
    acc = ac;
    wdata = d;
    v = q && legal(a, w, ac);
    #1;
    check("fault", fault, q && !v);
    if (r) begin
      check("rst_irq", irq, 0);
      check("rst_sf", soc_fault, 0);
    end
    e = edge_n + 1;
    if (r) begin
      model_reset();
      st = '{resp: 1'b0, irq: 1'b0, sf: 1'b0, faddr: '0};
    end else begin
      model_edge(e, v, w, a, d, rdx);
      st.resp = v;
      st.irq = m_irq;
      st.sf = (m_mode == M_FIRE);
      st.faddr = st.sf ? m_load : '0;
      if (v) rsp_q.push_back('{rd: !w, data: rdx});
    end
    stat_q.push_back(st);
    edge_n = e;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 4'd0, 2'd0, '0);
  endtask

  task automatic wr(logic [3:0] a, logic [1:0] ac, logic [31:0] d);
    step(0, 1, 1, a, ac, d);
  endtask

  task automatic rd(logic [3:0] a, logic [1:0] ac);
    step(0, 1, 0, a, ac, '0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 4'd0, 2'd0, '0);
    step(1, 0, 0, 4'd0, 2'd0, '0);
    step(0, 0, 0, 4'd0, 2'd0, '0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares outputs settled after each edge with queued expectations
  initial begin
    stat_t st;
    rsp_t rs;
    forever begin
      @(posedge clk);
      #2;
      if (stat_q.size() != 0) begin
        st = stat_q.pop_front();
        check("resp", resp, st.resp);
        check("irq", irq, st.irq);
        check("soc_fault", soc_fault, st.sf);
        check("cause", soc_fault_cause, st.sf ? CAUSE : 8'h00);
        check("fault_addr", soc_fault_addr, st.faddr);
        if (st.resp && rsp_q.size() != 0) begin
          rs = rsp_q.pop_front();
          if (rs.rd) check("rdata", rdata, rs.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (irq === 1'b1) irq_hi++;
    if (soc_fault === 1'b1) sf_hi++;
  end

  initial begin
    int r;
    int base_irq;
    int base_sf;
    logic [31:0] d;
    logic [3:0] ra;
    rst = 1'b1;
    req = 1'b0;
    w_rb = 1'b0;
    addr = '0;
    acc = '0;
    wdata = '0;
    model_reset();

    step(1, 0, 0, 4'd0, 2'd0, '0);
    step(1, 0, 0, 4'd0, 2'd0, '0);
    after_edge();
    check("reset_rdata", rdata, 0);
    check("reset_resp", resp, 0);
    check("reset_irq", irq, 0);
    check("reset_sf", soc_fault, 0);
    check("reset_faddr", soc_fault_addr, 0);
    step(0, 0, 0, 4'd0, 2'd0, '0);
    rd(4'd8, A4);
    rd(4'd4, A4);
    rd(4'd0, A2);

    // expiry without kicks
    wr(4'd4, A4, 32'd3);
    wr(4'd0, A2, 32'd1);
    idle(15);
    after_edge();
    check("t1_irq_early", irq, 0);
    idle(1);
    after_edge();
    check("t1_irq_16", irq, 1);
    idle(15);
    after_edge();
    check("t1_sf_early", soc_fault, 0);
    idle(1);
    after_edge();
    check("t1_sf_32", soc_fault, 1);
    check("t1_cause", soc_fault_cause, 8'h10);
    check("t1_addr", soc_fault_addr, 3);
    idle(1);
    after_edge();
    check("t1_sf_once", soc_fault, 0);
    check("t1_irq_clr", irq, 0);
    rd(4'd0, A2);

    // regular kicking keeps the watchdog quiet
    do_reset();
    wr(4'd4, A4, 32'd3);
    wr(4'd0, A2, 32'd1);
    base_irq = irq_hi;
    base_sf = sf_hi;
    for (int k = 0; k < 20; k++) begin
      wr(4'd2, A2, {16'h0, KEY});
      idle(9);
    end
    check("t2_no_irq", irq_hi - base_irq, 0);
    check("t2_no_sf", sf_hi - base_sf, 0);

    // bad key in WARN
    do_reset();
    wr(4'd4, A4, 32'd3);
    wr(4'd0, A2, 32'd1);
    idle(17);
    wr(4'd2, A2, 32'h1234);
    after_edge();
    check("t3_resp", resp, 1);
    check("t3_sf", soc_fault, 1);
    idle(2);

    // lock and invalid accesses
    do_reset();
    wr(4'd4, A4, 32'd7);
    wr(4'd0, A2, 32'd3);
    wr(4'd4, A4, 32'd9);
    rd(4'd4, A4);
    after_edge();
    check("t4_load_old", rdata, 7);
    rd(4'd8, A2);
    rd(4'd6, A4);
    rd(4'd0, A2);
    after_edge();
    check("t5_resp", resp, 1);
    check("t5_ctrl", rdata, 3);
    wr(4'd0, A2, 32'd0);
    idle(70);

    // kick on the expiring tick, then disable on the expiring tick
    do_reset();
    wr(4'd4, A4, 32'd3);
    wr(4'd0, A2, 32'd1);
    idle(15);
    wr(4'd2, A2, {16'h0, KEY});
    after_edge();
    check("t6_kick_irq", irq, 0);
    rd(4'd8, A4);
    after_edge();
    check("t6_cnt", rdata, 3);
    idle(14);
    wr(4'd0, A2, 32'd0);
    after_edge();
    check("t6_dis_irq", irq, 0);
    rd(4'd8, A4);

    // async reset during WARN
    wr(4'd0, A2, 32'd1);
    idle(17);
    after_edge();
    check("t6_warn", irq, 1);
    base_sf = sf_hi;
    step(1, 0, 0, 4'd0, 2'd0, '0);
    step(1, 0, 0, 4'd0, 2'd0, '0);
    step(0, 0, 0, 4'd0, 2'd0, '0);
    idle(40);
    check("t6_rst_no_sf", sf_hi - base_sf, 0);

    // randomised traffic, LOAD kept small so both stages expire often
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        idle(1);
      end else if (r < 68) begin
        d = ($urandom_range(0, 9) < 8) ? {16'h0, KEY} : $urandom;
        wr(4'd2, A2, d);
      end else if (r < 78) begin
        case ($urandom_range(0, 3))
          0: ra = 4'd0;
          1: ra = 4'd2;
          2: ra = 4'd4;
          default: ra = 4'd8;
        endcase
        rd(ra, (ra < 4'd4) ? A2 : A4);
      end else if (r < 84) begin
        wr(4'd4, A4, 32'($urandom_range(0, 6)));
      end else if (r < 92) begin
        d = '0;
        d[0] = 1'($urandom_range(0, 1));
        d[1] = ($urandom_range(0, 29) == 0);
        wr(4'd0, A2, d);
      end else if (r < 97) begin
        step(0, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), $urandom);
      end else begin
        do_reset();
      end
    end

    idle(2);
    @(posedge clk);
    #3;
    check("drain", stat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
